// File: rtl/cpu_translator.sv
// rtl/cpu_translator.sv - AXI4-Lite slave to single shared core request/response port
//
// Purpose: independent write (AW/W/B) and read (AR/R) FSMs feed one core
// request port with at most one core transaction outstanding. When both
// FSMs want the port at the same time, the write is granted first.
//
// Optional feature macro: CPU_TRANSLATOR_ALIGN_CHECK_EN
//   defined   - addresses with addr[1:0]!=0 are not issued; SLVERR is returned
//               one cycle after entering ISSUE (read data 0)
//   undefined - all addresses are forwarded unchanged
//
// Ports:
//   clk, rst_n               clock; asynchronous reset, asserted when rst_n=1
//   s_aw*, s_w*, s_b*        AXI4-Lite write address / data / response
//   s_ar*, s_r*              AXI4-Lite read address / data
//   core_req_*               shared core request (valid/ready, we, addr, wdata, wstrb)
//   core_resp_*              single-cycle core response pulse
//   dbg_w_state, dbg_r_state FSM state encodings
module cpu_translator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic                    core_req_valid,
  input  logic                    core_req_ready,
  output logic                    core_req_we,
  output logic [ADDR_WIDTH-1:0]   core_req_addr,
  output logic [DATA_WIDTH-1:0]   core_req_wdata,
  output logic [DATA_WIDTH/8-1:0] core_req_wstrb,
  input  logic                    core_resp_valid,
  input  logic                    core_resp_is_write,
  input  logic [DATA_WIDTH-1:0]   core_resp_rdata,
  input  logic [1:0]              core_resp_resp,
  output logic [2:0]              dbg_w_state,
  output logic [1:0]              dbg_r_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_GOT_AW = 3'd1,
    W_GOT_W  = 3'd2,
    W_ISSUE  = 3'd3,
    W_WAIT   = 3'd4,
    W_BRESP  = 3'd5
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_RESP  = 2'd3
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  core_busy;
  logic                  busy_we;
  // Once a request is presented but not accepted, the grant is frozen so a
  // later-arriving write cannot swap the payload under a stalled read.
  logic                  lock_valid;
  logic                  lock_we;

  logic aw_hs, w_hs, ar_hs;
  logic w_misalign, r_misalign;
  logic w_want, r_want, sel_we, issue_hs;
  logic resp_w, resp_r;

`ifdef CPU_TRANSLATOR_ALIGN_CHECK_EN
  assign w_misalign = (aw_addr_q[1:0] != 2'b00);
  assign r_misalign = (ar_addr_q[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
  assign r_misalign = 1'b0;
`endif

  // Readies are state decodes only; held low while reset is asserted.
  assign s_awready = !rst_n && ((w_state == W_IDLE) || (w_state == W_GOT_W));
  assign s_wready  = !rst_n && ((w_state == W_IDLE) || (w_state == W_GOT_AW));
  assign s_arready = !rst_n && (r_state == R_IDLE);

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  assign w_want = (w_state == W_ISSUE) && !w_misalign;
  assign r_want = (r_state == R_ISSUE) && !r_misalign;
  assign sel_we = lock_valid ? lock_we : w_want;

  assign core_req_valid = !core_busy && (w_want || r_want);
  assign core_req_we    = sel_we;
  assign core_req_addr  = sel_we ? aw_addr_q : ar_addr_q;
  assign core_req_wdata = sel_we ? w_data_q : '0;
  assign core_req_wstrb = sel_we ? w_strb_q : '0;
  assign issue_hs       = core_req_valid && core_req_ready;

  // Responses count only if they match the type of the outstanding request.
  assign resp_w = core_resp_valid && core_busy && busy_we && core_resp_is_write;
  assign resp_r = core_resp_valid && core_busy && !busy_we && !core_resp_is_write;

  assign s_bvalid    = (w_state == W_BRESP);
  assign s_bresp     = bresp_q;
  assign s_rvalid    = (r_state == R_RESP);
  assign s_rdata     = rdata_q;
  assign s_rresp     = rresp_q;
  assign dbg_w_state = w_state;
  assign dbg_r_state = r_state;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_ISSUE;
        else if (aw_hs)    w_next = W_GOT_AW;
        else if (w_hs)     w_next = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)  w_next = W_ISSUE;
      W_GOT_W:  if (aw_hs) w_next = W_ISSUE;
      W_ISSUE: begin
        if (w_misalign)             w_next = W_BRESP;
        else if (issue_hs && sel_we) w_next = W_WAIT;
      end
      W_WAIT:  if (resp_w)   w_next = W_BRESP;
      W_BRESP: if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_ISSUE;
      R_ISSUE: begin
        if (r_misalign)               r_next = R_RESP;
        else if (issue_hs && !sel_we) r_next = R_WAIT;
      end
      R_WAIT: if (resp_r)   r_next = R_RESP;
      R_RESP: if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ar_addr_q  <= '0;
      bresp_q    <= 2'b00;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      core_busy  <= 1'b0;
      busy_we    <= 1'b0;
      lock_valid <= 1'b0;
      lock_we    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;

      if (aw_hs) aw_addr_q <= s_awaddr;
      if (w_hs) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (ar_hs) ar_addr_q <= s_araddr;

      if (resp_w)
        bresp_q <= core_resp_resp;
      else if ((w_state == W_ISSUE) && w_misalign)
        bresp_q <= 2'b10;

      if (resp_r) begin
        rdata_q <= core_resp_rdata;
        rresp_q <= core_resp_resp;
      end else if ((r_state == R_ISSUE) && r_misalign) begin
        rdata_q <= '0;
        rresp_q <= 2'b10;
      end

      if (issue_hs) begin
        core_busy <= 1'b1;
        busy_we   <= sel_we;
      end else if (resp_w || resp_r) begin
        core_busy <= 1'b0;
      end

      if (core_req_valid && !core_req_ready) begin
        lock_valid <= 1'b1;
        lock_we    <= sel_we;
      end else begin
        lock_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_translator.sv
// tb/tb_cpu_translator.sv - directed self-checking bench for cpu_translator
module tb_cpu_translator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic        core_req_valid, core_req_ready, core_req_we;
  logic [31:0] core_req_addr, core_req_wdata;
  logic [3:0]  core_req_wstrb;
  logic        core_resp_valid, core_resp_is_write;
  logic [31:0] core_resp_rdata;
  logic [1:0]  core_resp_resp;
  logic [2:0]  dbg_w_state;
  logic [1:0]  dbg_r_state;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_translator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
    .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
    .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
    core_req_ready = 1; core_resp_valid = 0; core_resp_is_write = 0;
    core_resp_rdata = '0; core_resp_resp = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1;
    repeat (5) step();
    rst_n = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    repeat (5) step();
    n_cmp++; if (s_bvalid !== 1'b0) begin n_bad++; $display("FAIL rst_bvalid got=%b exp=0", s_bvalid); end
    n_cmp++; if (s_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got=%b exp=0", s_rvalid); end
    n_cmp++; if (core_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got=%b exp=0", core_req_valid); end
    n_cmp++; if (dbg_w_state !== 3'd0) begin n_bad++; $display("FAIL rst_dbg_w got=%0d exp=0", dbg_w_state); end
    n_cmp++; if (dbg_r_state !== 2'd0) begin n_bad++; $display("FAIL rst_dbg_r got=%0d exp=0", dbg_r_state); end
    rst_n = 0;
    step();
    n_cmp++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin n_bad++; $display("FAIL rst_readies got=%b exp=111", {s_awready, s_wready, s_arready}); end
  endtask

  task automatic test_read_during_write_wait();
    s_awaddr = 32'h0; s_awvalid = 1;
    step();
    s_awvalid = 0;
    n_cmp++; if (dbg_w_state !== 3'd1) begin n_bad++; $display("FAIL aw_only_state got=%0d exp=1", dbg_w_state); end
    n_cmp++; if ({s_awready, s_wready} !== 2'b01) begin n_bad++; $display("FAIL got_aw_readies got=%b exp=01", {s_awready, s_wready}); end
    step();
    s_araddr = 32'h10; s_arvalid = 1;
    step();
    s_arvalid = 0;
    n_cmp++; if (core_req_valid !== 1'b1) begin n_bad++; $display("FAIL rd_issue_valid got=%b exp=1", core_req_valid); end
    n_cmp++; if (core_req_we !== 1'b0) begin n_bad++; $display("FAIL rd_issue_we got=%b exp=0", core_req_we); end
    n_cmp++; if (core_req_addr !== 32'h10) begin n_bad++; $display("FAIL rd_issue_addr got=%h exp=%h", core_req_addr, 32'h10); end
    n_cmp++; if (core_req_wstrb !== 4'h0) begin n_bad++; $display("FAIL rd_issue_wstrb got=%h exp=0", core_req_wstrb); end
    step();
    n_cmp++; if (dbg_r_state !== 2'd2) begin n_bad++; $display("FAIL rd_wait_state got=%0d exp=2", dbg_r_state); end
    n_cmp++; if (dbg_w_state !== 3'd1) begin n_bad++; $display("FAIL w_still_got_aw got=%0d exp=1", dbg_w_state); end
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
    step();
    s_wvalid = 0;
    n_cmp++; if (dbg_w_state !== 3'd3) begin n_bad++; $display("FAIL w_issue_state got=%0d exp=3", dbg_w_state); end
    n_cmp++; if (core_req_valid !== 1'b0) begin n_bad++; $display("FAIL busy_blocks_req got=%b exp=0", core_req_valid); end
  endtask

  task automatic test_read_complete();
    core_resp_valid = 1; core_resp_is_write = 0; core_resp_rdata = 32'h12345678; core_resp_resp = 2'b00;
    step();
    core_resp_valid = 0;
    n_cmp++; if (s_rvalid !== 1'b1) begin n_bad++; $display("FAIL rvalid_set got=%b exp=1", s_rvalid); end
    n_cmp++; if (s_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rdata got=%h exp=%h", s_rdata, 32'h12345678); end
    n_cmp++; if (s_rresp !== 2'b00) begin n_bad++; $display("FAIL rresp got=%b exp=00", s_rresp); end
    n_cmp++; if (core_req_valid !== 1'b1) begin n_bad++; $display("FAIL wr_issue_valid got=%b exp=1", core_req_valid); end
    n_cmp++; if (core_req_we !== 1'b1) begin n_bad++; $display("FAIL wr_issue_we got=%b exp=1", core_req_we); end
    n_cmp++; if (core_req_addr !== 32'h0) begin n_bad++; $display("FAIL wr_issue_addr got=%h exp=0", core_req_addr); end
    n_cmp++; if (core_req_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_issue_wdata got=%h exp=%h", core_req_wdata, 32'hDEADBEEF); end
    n_cmp++; if (core_req_wstrb !== 4'hF) begin n_bad++; $display("FAIL wr_issue_wstrb got=%h exp=f", core_req_wstrb); end
    step();
    n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h12345678) begin n_bad++; $display("FAIL r_hold got=%b/%h exp=1/%h", s_rvalid, s_rdata, 32'h12345678); end
    n_cmp++; if (dbg_w_state !== 3'd4) begin n_bad++; $display("FAIL w_wait_state got=%0d exp=4", dbg_w_state); end
    s_rready = 1;
    step();
    s_rready = 0;
    n_cmp++; if (s_rvalid !== 1'b0 || dbg_r_state !== 2'd0) begin n_bad++; $display("FAIL r_release got=%b/%0d exp=0/0", s_rvalid, dbg_r_state); end
  endtask

  task automatic test_write_complete();
    core_resp_valid = 1; core_resp_is_write = 1; core_resp_resp = 2'b00;
    step();
    core_resp_valid = 0;
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin n_bad++; $display("FAIL bvalid_set got=%b/%b exp=1/00", s_bvalid, s_bresp); end
    repeat (2) step();
    n_cmp++; if (s_bvalid !== 1'b1) begin n_bad++; $display("FAIL b_hold got=%b exp=1", s_bvalid); end
    s_bready = 1;
    step();
    s_bready = 0;
    n_cmp++; if (s_bvalid !== 1'b0 || dbg_w_state !== 3'd0) begin n_bad++; $display("FAIL b_release got=%b/%0d exp=0/0", s_bvalid, dbg_w_state); end
  endtask

  task automatic test_back_to_back();
    int  waited;
    bit  seen;
    s_awaddr = 32'h20; s_awvalid = 1; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'h3; s_wvalid = 1;
    s_araddr = 32'h24; s_arvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    waited = 0; seen = 0;
    while (!seen && waited < 8) begin
      if (core_req_valid && core_req_we) seen = 1;
      else begin step(); waited++; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL w_issue_bound got=timeout exp=issue within 8 cycles"); end
    n_cmp++; if (core_req_addr !== 32'h20 || core_req_wstrb !== 4'h3) begin n_bad++; $display("FAIL both_write_first got=%h/%h exp=20/3", core_req_addr, core_req_wstrb); end
    n_cmp++; if (dbg_r_state !== 2'd1) begin n_bad++; $display("FAIL rd_waits_issue got=%0d exp=1", dbg_r_state); end
    step();
    n_cmp++; if (core_req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_blocked got=%b exp=0", core_req_valid); end
    core_resp_valid = 1; core_resp_is_write = 0;
    step();
    core_resp_valid = 0;
    n_cmp++; if (dbg_r_state !== 2'd1 || dbg_w_state !== 3'd4) begin n_bad++; $display("FAIL wrong_type_ignored got=%0d/%0d exp=1/4", dbg_r_state, dbg_w_state); end
    core_resp_valid = 1; core_resp_is_write = 1; core_resp_resp = 2'b01;
    step();
    core_resp_valid = 0;
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b01) begin n_bad++; $display("FAIL b2b_bresp got=%b/%b exp=1/01", s_bvalid, s_bresp); end
    n_cmp++; if (core_req_valid !== 1'b1 || core_req_we !== 1'b0 || core_req_addr !== 32'h24 || core_req_wdata !== 32'h0) begin n_bad++; $display("FAIL rd_after_wr got=%b/%b/%h/%h exp=1/0/24/0", core_req_valid, core_req_we, core_req_addr, core_req_wdata); end
    s_bready = 1;
    step();
    s_bready = 0;
    n_cmp++; if (dbg_r_state !== 2'd2 || s_bvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_wait got=%0d/%b exp=2/0", dbg_r_state, s_bvalid); end
    core_resp_valid = 1; core_resp_is_write = 0; core_resp_rdata = 32'hCAFEF00D; core_resp_resp = 2'b10;
    step();
    core_resp_valid = 0;
    n_cmp++; if (s_rdata !== 32'hCAFEF00D || s_rresp !== 2'b10) begin n_bad++; $display("FAIL b2b_rdata got=%h/%b exp=cafef00d/10", s_rdata, s_rresp); end
    s_rready = 1;
    step();
    s_rready = 0;
    n_cmp++; if (s_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_r_release got=%b exp=0", s_rvalid); end
  endtask

  task automatic test_ready_stall();
    core_req_ready = 0;
    s_awaddr = 32'h40; s_awvalid = 1; s_wdata = 32'h11223344; s_wstrb = 4'hC; s_wvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (core_req_valid !== 1'b1 || core_req_addr !== 32'h40 || core_req_wdata !== 32'h11223344 || core_req_wstrb !== 4'hC) begin
        n_bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%h exp=1/40/11223344/c", i, core_req_valid, core_req_addr, core_req_wdata, core_req_wstrb); end
      step();
    end
    core_req_ready = 1;
    n_cmp++; if (dbg_w_state !== 3'd3) begin n_bad++; $display("FAIL stall_no_issue got=%0d exp=3", dbg_w_state); end
    step();
    n_cmp++; if (dbg_w_state !== 3'd4 || core_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_issue got=%0d/%b exp=4/0", dbg_w_state, core_req_valid); end
    core_resp_valid = 1; core_resp_is_write = 1; core_resp_resp = 2'b00;
    step();
    core_resp_valid = 0; s_bready = 1;
    step();
    s_bready = 0;
  endtask

  task automatic test_misaligned();
    s_awaddr = 32'h43; s_awvalid = 1; s_wdata = 32'h55; s_wstrb = 4'h1; s_wvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0;
`ifdef CPU_TRANSLATOR_ALIGN_CHECK_EN
    n_cmp++; if (core_req_valid !== 1'b0) begin n_bad++; $display("FAIL misalign_no_req got=%b exp=0", core_req_valid); end
    step();
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b10) begin n_bad++; $display("FAIL misalign_slverr got=%b/%b exp=1/10", s_bvalid, s_bresp); end
`else
    n_cmp++; if (core_req_valid !== 1'b1 || core_req_addr !== 32'h43) begin n_bad++; $display("FAIL misalign_forward got=%b/%h exp=1/43", core_req_valid, core_req_addr); end
    step();
    core_resp_valid = 1; core_resp_is_write = 1; core_resp_resp = 2'b00;
    step();
    core_resp_valid = 0;
    n_cmp++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin n_bad++; $display("FAIL misalign_okay got=%b/%b exp=1/00", s_bvalid, s_bresp); end
`endif
    s_bready = 1;
    step();
    s_bready = 0;
  endtask

  task automatic test_reset_mid_op();
    s_awaddr = 32'h80; s_awvalid = 1;
    step();
    s_awvalid = 0;
    s_araddr = 32'h84; s_arvalid = 1; core_req_ready = 0;
    step();
    s_arvalid = 0;
    rst_n = 1;
    #1;
    n_cmp++; if (dbg_w_state !== 3'd0 || dbg_r_state !== 2'd0 || core_req_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset got=%0d/%0d/%b exp=0/0/0", dbg_w_state, dbg_r_state, core_req_valid); end
    @(negedge clk);
    rst_n = 0; core_req_ready = 1;
    step();
    n_cmp++; if (dbg_w_state !== 3'd0 || core_req_valid !== 1'b0) begin n_bad++; $display("FAIL after_reset_idle got=%0d/%b exp=0/0", dbg_w_state, core_req_valid); end
  endtask

  initial begin
    rst_n = 1;
    test_reset();
    test_read_during_write_wait();
    test_read_complete();
    test_write_complete();
    test_back_to_back();
    test_ready_stall();
    test_misaligned();
    test_reset_mid_op();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_translator.md
Name: cpu_translator

Overview:
- AXI4-Lite slave front end that converts AW/W/B and AR/R channel traffic into a single shared core request/response port.
- Sits between an AXI4-Lite master (CPU/interconnect) and a core or cache controller.
- Independent write and read FSMs share one request port, with at most one core transaction outstanding.
- Exposes FSM state on debug outputs.

Parameters:
- ADDR_WIDTH, 32, address width of AXI and core request.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid / s_awready  in / out  1  AW handshake
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  byte strobes
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  B handshake
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid / s_arready  in / out  1  AR handshake
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  R handshake
- core_req_valid  out  1  request valid
- core_req_ready  in  1  core accepts request
- core_req_we  out  1  1=write, 0=read
- core_req_addr  out  ADDR_WIDTH  request address
- core_req_wdata  out  DATA_WIDTH  write data
- core_req_wstrb  out  DATA_WIDTH/8  write strobes
- core_resp_valid  in  1  single-cycle response pulse
- core_resp_is_write  in  1  response belongs to a write
- core_resp_rdata  in  DATA_WIDTH  read data
- core_resp_resp  in  2  AXI response code
- dbg_w_state  out  3  write FSM state encoding
- dbg_r_state  out  2  read FSM state encoding

Behaviour:
- Reset (rst_n=1, async) state:
  - Both FSMs in IDLE.
  - All registered outputs, data/addr latches, core_busy and dbg outputs are 0.
  - Ready outputs follow state: s_awready=s_wready=s_arready=1 once out of reset.
- Write FSM states (dbg_w_state):
  - W_IDLE=0, W_GOT_AW=1, W_GOT_W=2, W_ISSUE=3, W_WAIT=4, W_BRESP=5.
- Write ready rules:
  - s_awready=1 in W_IDLE and W_GOT_W.
  - s_wready=1 in W_IDLE and W_GOT_AW.
  - Both readies are decoded from state only, never from valid.
- Write transitions:
  - W_IDLE: AW only → GOT_AW (latch awaddr). W only → GOT_W (latch wdata/wstrb). Both in the same cycle → W_ISSUE.
  - GOT_AW + W handshake → W_ISSUE. GOT_W + AW handshake → W_ISSUE.
  - W_ISSUE → W_WAIT on core_req_valid&&core_req_ready with core_req_we=1.
  - W_WAIT → W_BRESP on core_resp_valid && core_resp_is_write. Latch s_bresp=core_resp_resp; s_bvalid=1 the next cycle.
  - W_BRESP holds s_bvalid and s_bresp stable until s_bready=1, then → W_IDLE.
- Read FSM states (dbg_r_state): R_IDLE=0, R_ISSUE=1, R_WAIT=2, R_RESP=3.
- Read rules:
  - s_arready=1 only in R_IDLE; handshake latches araddr → R_ISSUE.
  - R_ISSUE → R_WAIT on issue handshake with core_req_we=0.
  - R_WAIT → R_RESP on core_resp_valid && !core_resp_is_write. Latch rdata/rresp; s_rvalid=1.
  - R_RESP holds s_rvalid, s_rdata and s_rresp until s_rready=1, then → R_IDLE.
- Core port arbitration:
  - core_busy is set on the issue handshake and cleared on a matching core_resp_valid.
  - core_req_valid=1 only when !core_busy and at least one FSM is in ISSUE.
  - If both FSMs are in ISSUE, write wins; read waits.
  - core_req_addr/wdata/wstrb/we are driven from the granted FSM's latches; wdata/wstrb are 0 for reads.
  - core_req_valid is held with stable payload until core_req_ready.
- Responses:
  - core_resp_valid whose is_write does not match the outstanding type, or arriving with no outstanding request, is ignored.
- Concurrency:
  - AW/W may arrive in any order and separated by any gap.
  - A read may be accepted and completed while the write waits for W data.
- Reset mid-operation returns everything to IDLE and discards latched transactions.

Optional Feature:
- Macro CPU_TRANSLATOR_ALIGN_CHECK_EN.
- When defined:
  - A write or read whose address[1:0]!=0 is not issued to the core.
  - The FSM goes directly from ISSUE to BRESP/RRESP with resp=2'b10 (SLVERR); read data is 0.
  - Response valid asserts one cycle after entering ISSUE.
- When undefined: all addresses are forwarded unchanged.

Test Plan:
- Reset for 5 cycles → all valids 0; dbg_w_state=0, dbg_r_state=0; s_awready, s_wready, s_arready=1 after release.
- AW 0x0 alone, then AR 0x10 two cycles later, then W 0xDEADBEEF/strb 0xF, with core_req_ready=1:
  - Read issues first (we=0, addr 0x10).
  - Write waits in GOT_AW (dbg 1) until W arrives.
- Read completion: core_resp_valid with is_write=0, rdata 0x12345678, resp 0 → s_rvalid=1, s_rdata=0x12345678, held until s_rready.
- Write completion:
  - After the read response, the write issues with addr 0, wdata 0xDEADBEEF, wstrb 0xF.
  - core_resp is_write=1, resp 0 → s_bvalid=1, bresp 0, held while s_bready=0; clears one cycle after s_bready=1.
- Simultaneous AW+W and AR with core idle → write issued first; read issued after the write response; W_ISSUE never lasts >8 cycles.
- core_req_ready=0 for 4 cycles during W_ISSUE → core_req_valid held with stable addr/data; issue occurs on the first ready cycle.
